// File: rtl/risc16_pkg.sv
// Shared ISA definitions for the 16-bit RISC core: field layout, opcode
// classes, the ID/EX payload and small decode helpers.
package risc16_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned REG_AW   = 4;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned IMM_W    = 4;

  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_LSB = 0;

  // Class boundaries: 0 NOP, 1..7 R, 8..11 I, 12..15 S
  localparam logic [OP_W-1:0] OP_NOP    = 4'h0;
  localparam logic [OP_W-1:0] OP_R_LAST = 4'h7;
  localparam logic [OP_W-1:0] OP_I_LAST = 4'hB;

  typedef enum logic [1:0] {
    CLS_NOP = 2'd0,
    CLS_R   = 2'd1,
    CLS_I   = 2'd2,
    CLS_S   = 2'd3
  } op_class_e;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] rd;
    logic              wr_en;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
  } id_ex_t;

  function automatic op_class_e op_class(input logic [OP_W-1:0] op);
    if (op == OP_NOP)         return CLS_NOP;
    else if (op <= OP_R_LAST) return CLS_R;
    else if (op <= OP_I_LAST) return CLS_I;
    else                      return CLS_S;
  endfunction

  function automatic logic reads_rs1(input op_class_e cls);
    return cls != CLS_NOP;
  endfunction

  function automatic logic reads_rs2_field(input op_class_e cls);
    return cls == CLS_R;
  endfunction

  function automatic logic reads_rd_field(input op_class_e cls);
    return cls == CLS_S;
  endfunction

  function automatic logic writes_rd(input op_class_e cls);
    return (cls == CLS_R) || (cls == CLS_I);
  endfunction

  function automatic logic [DATA_W-1:0] sext_imm4(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard with set-wins priority and three
// combinational lookup ports.
module reg_scoreboard
  import risc16_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [REG_AW-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_addr,
  input  logic [REG_AW-1:0]   look_a,
  input  logic [REG_AW-1:0]   look_b,
  input  logic [REG_AW-1:0]   look_c,
  output logic [NUM_REGS-1:0] busy,
  output logic                hit_a_c,
  output logic                hit_b_c,
  output logic                hit_c_c
);

  logic [NUM_REGS-1:0] busy_d;

  // Clear first so a same-cycle set on the same register wins
  always_comb begin
    busy_d = busy;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_d;
  end

  assign hit_a_c = busy[look_a];
  assign hit_b_c = busy[look_b];
  assign hit_c_c = busy[look_c];

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes the fetched word, drives RF read addresses,
// stalls on scoreboard hazards and loads the ID/EX pipeline register.
module decode_issue_stage
  import risc16_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  input  logic [DATA_W-1:0]   if_instr,
  output logic                if_ready,
  output logic [REG_AW-1:0]   rf_read_add_1,
  output logic [REG_AW-1:0]   rf_read_add_2,
  input  logic [DATA_W-1:0]   rf_read_data_1,
  input  logic [DATA_W-1:0]   rf_read_data_2,
  input  logic                wb_valid,
  input  logic [REG_AW-1:0]   wb_rd,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [OP_W-1:0]     ex_opcode,
  output logic [REG_AW-1:0]   ex_rd,
  output logic                ex_wr_en,
  output logic [DATA_W-1:0]   ex_op_a,
  output logic [DATA_W-1:0]   ex_op_b,
  output logic [NUM_REGS-1:0] busy
);

  logic [OP_W-1:0]   opcode;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  op_class_e         cls;
  logic              hit_rs1;
  logic              hit_rs2;
  logic              hit_rd;
  logic              hazard;
  logic              transfer;
  logic              sb_set;
  id_ex_t            id_ex_d;
  id_ex_t            id_ex_q;

  assign opcode = if_instr[OP_LSB  +: OP_W];
  assign rd     = if_instr[RD_LSB  +: REG_AW];
  assign rs1    = if_instr[RS1_LSB +: REG_AW];
  assign rs2    = if_instr[RS2_LSB +: REG_AW];
  assign cls    = op_class(opcode);

  assign rf_read_add_1 = rs1;

  // Second read port carries rs2 for R-type and the rd field for stores
  always_comb begin
    rf_read_add_2 = '0;
    if (reads_rs2_field(cls))     rf_read_add_2 = rs2;
    else if (reads_rd_field(cls)) rf_read_add_2 = rd;
  end

  // The rd lookup covers both the S-type data read and the WAW check
  assign hazard = if_valid &&
                  ((reads_rs1(cls) && hit_rs1) ||
                   (reads_rs2_field(cls) && hit_rs2) ||
                   ((reads_rd_field(cls) || writes_rd(cls)) && hit_rd));

  assign if_ready = !rst && !hazard && (!ex_valid || ex_ready);
  assign transfer = if_valid && if_ready;
  assign sb_set   = transfer && writes_rd(cls);

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set),
    .set_addr (rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_rd),
    .look_a   (rs1),
    .look_b   (rs2),
    .look_c   (rd),
    .busy     (busy),
    .hit_a_c  (hit_rs1),
    .hit_b_c  (hit_rs2),
    .hit_c_c  (hit_rd)
  );

  always_comb begin
    id_ex_d        = '0;
    id_ex_d.opcode = opcode;
    id_ex_d.rd     = rd;
    id_ex_d.wr_en  = writes_rd(cls);
    unique case (cls)
      CLS_R, CLS_S: begin
        id_ex_d.op_a = rf_read_data_1;
        id_ex_d.op_b = rf_read_data_2;
      end
      CLS_I: begin
        id_ex_d.op_a = rf_read_data_1;
        id_ex_d.op_b = sext_imm4(if_instr[RS2_LSB +: IMM_W]);
      end
      default: begin
        id_ex_d.op_a = '0;
        id_ex_d.op_b = '0;
      end
    endcase
  end

  // ID/EX register: payload holds unless a new instruction transfers in
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q  <= '0;
      ex_valid <= 1'b0;
    end else if (transfer) begin
      id_ex_q  <= id_ex_d;
      ex_valid <= 1'b1;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  assign ex_opcode = id_ex_q.opcode;
  assign ex_rd     = id_ex_q.rd;
  assign ex_wr_en  = id_ex_q.wr_en;
  assign ex_op_a   = id_ex_q.op_a;
  assign ex_op_b   = id_ex_q.op_b;

endmodule
